// File: rtl/ctrl_pipe_if.sv
// Pipeline-control bundle between the ID-stage decoder and the control pipeline.
// Groups decoder inputs, stage control outputs and hazard/forwarding outputs.
interface ctrl_pipe_if;
  logic [8:0] ctrl_i;
  logic [4:0] id_rs_i;
  logic [4:0] id_rt_i;
  logic [4:0] id_rd_i;
  logic       flush_i;

  logic       ex_regdst_o;
  logic [1:0] ex_aluop_o;
  logic       ex_alusrc_o;
  logic       mem_read_o;
  logic       mem_write_o;
  logic       wb_regwrite_o;
  logic       wb_memtoreg_o;
  logic [4:0] wb_wreg_o;
  logic [1:0] fwd_a_o;
  logic [1:0] fwd_b_o;
  logic       pc_write_o;
  logic       ifid_write_o;
  logic       stall_o;

  modport master (
    output ctrl_i, id_rs_i, id_rt_i, id_rd_i, flush_i,
    input  ex_regdst_o, ex_aluop_o, ex_alusrc_o, mem_read_o, mem_write_o,
           wb_regwrite_o, wb_memtoreg_o, wb_wreg_o, fwd_a_o, fwd_b_o,
           pc_write_o, ifid_write_o, stall_o
  );

  modport slave (
    input  ctrl_i, id_rs_i, id_rt_i, id_rd_i, flush_i,
    output ex_regdst_o, ex_aluop_o, ex_alusrc_o, mem_read_o, mem_write_o,
           wb_regwrite_o, wb_memtoreg_o, wb_wreg_o, fwd_a_o, fwd_b_o,
           pc_write_o, ifid_write_o, stall_o
  );
endinterface

// File: rtl/ctrl_pipe.sv
// Control pipeline for a 5-stage MIPS-style core: ID/EX, EX/MEM, MEM/WB control
// registers plus load-use hazard detection and EX-stage forwarding selects.
module ctrl_pipe (
  input  logic        clk_i,
  input  logic        rst_i,
  ctrl_pipe_if.slave  bus
);

  localparam int B_REGWRITE = 8;
  localparam int B_MEMTOREG = 7;
  localparam int B_MEMREAD  = 5;
  localparam int B_MEMWRITE = 4;
  localparam int B_REGDST   = 3;
  localparam int B_ALUOP_HI = 2;
  localparam int B_ALUOP_LO = 1;
  localparam int B_ALUSRC   = 0;

  typedef struct packed {
    logic [7:0] ctrl;  // decoder bundle with the reserved bit dropped
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } idex_t;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memread;
    logic       memwrite;
    logic [4:0] wreg;
  } exmem_t;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic [4:0] wreg;
  } memwb_t;

  idex_t  idex_q,  idex_d;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;

  logic       stall;
  logic [4:0] ex_wreg;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       ctrl_unused;

  // Reserved decoder bit carries no meaning anywhere in the pipeline.
  assign ctrl_unused = bus.ctrl_i[6];

  // Bundle re-indexed without bit 6: [7] RegWrite .. [0] ALUSrc.
  function automatic logic idex_bit(input logic [7:0] c, input int b);
    return (b > 6) ? c[b-1] : c[b];
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    stall   = 1'b0;
    idex_d  = '0;
    exmem_d = '0;
    memwb_d = '0;
    fwd_a   = 2'b00;
    fwd_b   = 2'b00;

    // Load-use: the load in EX writes a register the ID instruction reads; flush wins.
    if (idex_bit(idex_q.ctrl, B_MEMREAD) && (idex_q.rt != 5'd0) &&
        ((idex_q.rt == bus.id_rs_i) || (idex_q.rt == bus.id_rt_i)) && !bus.flush_i)
      stall = 1'b1;

    if (!stall && !bus.flush_i) begin
      idex_d.ctrl = {bus.ctrl_i[8:7], bus.ctrl_i[5:0]};
      idex_d.rs   = bus.id_rs_i;
      idex_d.rt   = bus.id_rt_i;
      idex_d.rd   = bus.id_rd_i;
    end

    ex_wreg = idex_bit(idex_q.ctrl, B_REGDST) ? idex_q.rd : idex_q.rt;

    exmem_d.regwrite = idex_bit(idex_q.ctrl, B_REGWRITE);
    exmem_d.memtoreg = idex_bit(idex_q.ctrl, B_MEMTOREG);
    exmem_d.memread  = idex_bit(idex_q.ctrl, B_MEMREAD);
    exmem_d.memwrite = idex_bit(idex_q.ctrl, B_MEMWRITE);
    exmem_d.wreg     = ex_wreg;

    memwb_d.regwrite = exmem_q.regwrite;
    memwb_d.memtoreg = exmem_q.memtoreg;
    memwb_d.wreg     = exmem_q.wreg;

    // MEM result is younger than WB, so it is checked first.
    if (exmem_q.regwrite && (exmem_q.wreg != 5'd0) && (exmem_q.wreg == idex_q.rs))
      fwd_a = 2'b10;
    else if (memwb_q.regwrite && (memwb_q.wreg != 5'd0) && (memwb_q.wreg == idex_q.rs))
      fwd_a = 2'b01;

    if (exmem_q.regwrite && (exmem_q.wreg != 5'd0) && (exmem_q.wreg == idex_q.rt))
      fwd_b = 2'b10;
    else if (memwb_q.regwrite && (memwb_q.wreg != 5'd0) && (memwb_q.wreg == idex_q.rt))
      fwd_b = 2'b01;
  end

  // NOTE: state registers use non-blocking assignments so all stages update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign bus.ex_regdst_o   = idex_bit(idex_q.ctrl, B_REGDST);
  assign bus.ex_aluop_o    = {idex_bit(idex_q.ctrl, B_ALUOP_HI), idex_bit(idex_q.ctrl, B_ALUOP_LO)};
  assign bus.ex_alusrc_o   = idex_bit(idex_q.ctrl, B_ALUSRC);
  assign bus.mem_read_o    = exmem_q.memread;
  assign bus.mem_write_o   = exmem_q.memwrite;
  assign bus.wb_regwrite_o = memwb_q.regwrite;
  assign bus.wb_memtoreg_o = memwb_q.memtoreg;
  assign bus.wb_wreg_o     = memwb_q.wreg;
  assign bus.fwd_a_o       = fwd_a;
  assign bus.fwd_b_o       = fwd_b;
  assign bus.stall_o       = stall;
  assign bus.pc_write_o    = !stall;
  assign bus.ifid_write_o  = !stall;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: stimulus queues hand-computed expectations
// tagged with a due cycle; a monitor compares them against the DUT outputs.
module tb_ctrl_pipe;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  ctrl_pipe_if bus();

  ctrl_pipe dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // Observation vector: {regdst, aluop[1:0], alusrc, mem_read, mem_write,
  //  wb_regwrite, wb_memtoreg, wb_wreg[4:0], fwd_a[1:0], fwd_b[1:0], pc_write, ifid_write, stall}
  localparam logic [19:0] M_EX  = 20'hF0000;
  localparam logic [19:0] M_MEM = 20'h0C000;
  localparam logic [19:0] M_WB  = 20'h03F80;
  localparam logic [19:0] M_FWD = 20'h00078;
  localparam logic [19:0] M_HAZ = 20'h00007;
  localparam logic [19:0] M_ALL = 20'hFFFFF;

  localparam logic [8:0] NOP    = 9'h000;
  localparam logic [8:0] R_TYPE = 9'h10C;  // RegWrite, RegDst, ALUOp=10
  localparam logic [8:0] LW     = 9'h1A1;  // RegWrite, MemtoReg, MemRead, ALUSrc
  localparam logic [8:0] LW_B6  = 9'h1E1;  // same load with the reserved bit set
  localparam logic [8:0] SW     = 9'h011;  // MemWrite, ALUSrc

  typedef struct {
    string       name;
    int          due;
    logic [19:0] val;
    logic [19:0] mask;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [19:0] e_ex(input logic rd, input logic [1:0] op, input logic src);
    return {rd, op, src, 16'b0};
  endfunction
  function automatic logic [19:0] e_mem(input logic r, input logic w);
    return {4'b0, r, w, 14'b0};
  endfunction
  function automatic logic [19:0] e_wb(input logic rw, input logic mtr, input logic [4:0] wreg);
    return {6'b0, rw, mtr, wreg, 7'b0};
  endfunction
  function automatic logic [19:0] e_fwd(input logic [1:0] a, input logic [1:0] b);
    return {13'b0, a, b, 3'b0};
  endfunction
  function automatic logic [19:0] e_haz(input logic pc, input logic ifid, input logic st);
    return {17'b0, pc, ifid, st};
  endfunction

  task automatic check(input string name, input logic [19:0] act,
                       input logic [19:0] exp, input logic [19:0] mask);
    n_tests++;
    if ((act & mask) !== (exp & mask)) begin
      n_fail++;
      $display("FAIL %s: got %05h want %05h (mask %05h) cycle %0d",
               name, act & mask, exp & mask, mask, cyc);
    end
  endtask

  task automatic push_exp(input string name, input int lat,
                          input logic [19:0] val, input logic [19:0] mask);
    exp_t e;
    e.name = name;
    e.due  = cyc + lat;
    e.val  = val;
    e.mask = mask;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [8:0] ctrl, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic flush);
    bus.ctrl_i  = ctrl;
    bus.id_rs_i = rs;
    bus.id_rt_i = rt;
    bus.id_rd_i = rd;
    bus.flush_i = flush;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: samples mid-cycle, and right after an asynchronous reset assertion.
  initial begin
    logic [19:0] obs;
    forever begin
      @(negedge clk_i or negedge rst_i);
      #1;
      obs = {bus.ex_regdst_o, bus.ex_aluop_o, bus.ex_alusrc_o, bus.mem_read_o,
             bus.mem_write_o, bus.wb_regwrite_o, bus.wb_memtoreg_o, bus.wb_wreg_o,
             bus.fwd_a_o, bus.fwd_b_o, bus.pc_write_o, bus.ifid_write_o, bus.stall_o};
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          check(sb[i].name, obs, sb[i].val, sb[i].mask);
          sb.delete(i);
        end else if (sb[i].due < cyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL %s: never sampled, due cycle %0d now %0d", sb[i].name, sb[i].due, cyc);
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    logic [19:0] haz_ok;
    haz_ok = e_haz(1'b1, 1'b1, 1'b0);

    drive(9'h1FF, 5'd1, 5'd1, 5'd1, 1'b0);
    step();
    push_exp("reset_hold", 0, haz_ok, M_ALL);
    step();
    rst_i = 1'b1;
    drive(NOP, 5'd0, 5'd0, 5'd0, 1'b0);

    // Latency of an R-type writing $5
    step();
    drive(R_TYPE, 5'd1, 5'd2, 5'd5, 1'b0);
    push_exp("rtype_haz", 0, haz_ok, M_HAZ);
    push_exp("rtype_ex", 1, e_ex(1'b1, 2'b10, 1'b0), M_EX);
    push_exp("rtype_fwd", 1, e_fwd(2'b00, 2'b00), M_FWD);
    push_exp("rtype_mem", 2, e_mem(1'b0, 1'b0), M_MEM);
    push_exp("rtype_wb", 3, e_wb(1'b1, 1'b0, 5'd5), M_WB);

    // Load with reserved bit set: destination is rt
    step();
    drive(LW_B6, 5'd4, 5'd9, 5'd31, 1'b0);
    push_exp("lw_ex", 1, e_ex(1'b0, 2'b00, 1'b1), M_EX);
    push_exp("lw_mem", 2, e_mem(1'b1, 1'b0), M_MEM);
    push_exp("lw_wb", 3, e_wb(1'b1, 1'b1, 5'd9), M_WB);

    // Store behind the load, no register overlap; rs=5 forwards from WB
    step();
    drive(SW, 5'd5, 5'd7, 5'd0, 1'b0);
    push_exp("sw_nostall", 0, haz_ok, M_HAZ);
    push_exp("sw_ex", 1, e_ex(1'b0, 2'b00, 1'b1), M_EX);
    push_exp("sw_fwd_wb", 1, e_fwd(2'b01, 2'b00), M_FWD);
    push_exp("sw_mem", 2, e_mem(1'b0, 1'b1), M_MEM);
    push_exp("sw_wb", 3, e_wb(1'b0, 1'b0, 5'd7), M_WB);

    // Two writers of $3 then a reader: MEM wins over WB
    step();
    drive(R_TYPE, 5'd0, 5'd0, 5'd3, 1'b0);
    step();
    drive(R_TYPE, 5'd0, 5'd0, 5'd3, 1'b0);
    step();
    drive(R_TYPE, 5'd3, 5'd3, 5'd10, 1'b0);
    push_exp("fwd_priority", 1, e_fwd(2'b10, 2'b10), M_FWD);

    // Writer of $0 in MEM never forwards
    step();
    drive(R_TYPE, 5'd1, 5'd2, 5'd0, 1'b0);
    step();
    drive(R_TYPE, 5'd0, 5'd3, 5'd11, 1'b0);
    push_exp("fwd_zero_reg", 1, e_fwd(2'b00, 2'b00), M_FWD);

    // Load-use on rs: one bubble, then WB forwarding
    step();
    drive(LW, 5'd2, 5'd8, 5'd0, 1'b0);
    step();
    drive(R_TYPE, 5'd8, 5'd1, 5'd12, 1'b0);
    push_exp("loaduse_stall", 0, e_haz(1'b0, 1'b0, 1'b1), M_HAZ);
    step();
    push_exp("loaduse_release", 0, haz_ok, M_HAZ);
    push_exp("bubble_ex", 0, e_ex(1'b0, 2'b00, 1'b0), M_EX);
    push_exp("loaduse_lw_mem", 0, e_mem(1'b1, 1'b0), M_MEM);
    push_exp("add_ex", 1, e_ex(1'b1, 2'b10, 1'b0), M_EX);
    push_exp("add_fwd_wb", 1, e_fwd(2'b01, 2'b00), M_FWD);
    push_exp("bubble_mem", 1, e_mem(1'b0, 1'b0), M_MEM);
    push_exp("bubble_wb", 2, e_wb(1'b0, 1'b0, 5'd0), M_WB);

    // Flush overrides a load-use match on rt
    step();
    drive(LW, 5'd0, 5'd13, 5'd0, 1'b0);
    push_exp("lw13_wb", 3, e_wb(1'b1, 1'b1, 5'd13), M_WB);
    step();
    drive(R_TYPE, 5'd1, 5'd13, 5'd14, 1'b1);
    push_exp("flush_nostall", 0, haz_ok, M_HAZ);
    push_exp("flush_bubble_ex", 1, e_ex(1'b0, 2'b00, 1'b0), M_EX);

    // Load-use on rt, then asynchronous reset mid-stall
    step();
    drive(LW, 5'd0, 5'd13, 5'd0, 1'b0);
    push_exp("after_flush_haz", 0, haz_ok, M_HAZ);
    step();
    drive(R_TYPE, 5'd2, 5'd13, 5'd14, 1'b0);
    push_exp("loaduse_rt_stall", 0, e_haz(1'b0, 1'b0, 1'b1), M_HAZ);
    #6;
    rst_i = 1'b0;
    push_exp("async_reset", 0, haz_ok, M_ALL);

    // First edge after release captures normally
    step();
    rst_i = 1'b1;
    drive(R_TYPE, 5'd0, 5'd0, 5'd6, 1'b0);
    push_exp("post_reset_idle", 0, haz_ok, M_ALL);
    push_exp("post_reset_ex", 1, e_ex(1'b1, 2'b10, 1'b0), M_EX);
    push_exp("post_reset_wb", 3, e_wb(1'b1, 1'b0, 5'd6), M_WB);

    step();
    drive(NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    repeat (5) step();

    foreach (sb[i]) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: still pending at end, due cycle %0d", sb[i].name, sb[i].due);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
